// File: rtl/sram_pkg.sv
// sram_pkg: FSM state type, read/write encodings and wait-state limits.
// SRAM_TURNAROUND_EN adds the TURN state used for read-to-write bus turnaround.
package sram_pkg;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
`ifdef SRAM_TURNAROUND_EN
        , ST_TURN = 2'd3
`endif
    } state_t;

    // Saturate an out-of-range wait count instead of wrapping it
    function automatic logic [CNT_W-1:0] wait_load(input int ws);
        if (ws > WAIT_MAX) begin
            return CNT_W'(WAIT_MAX);
        end
        if (ws < 0) begin
            return '0;
        end
        return CNT_W'(ws);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter timing the SRAM access phase.
// Stops at zero; o_zero marks the last access cycle.
module sram_wait_counter
    import sram_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_wait_ctrl.sv
// sram_wait_ctrl: four-phase bus to asynchronous SRAM bridge with wait states.
// Define SRAM_TURNAROUND_EN to insert a TURN cycle between a read and a write.
module sram_wait_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic                bus_enable,
    input  logic [DATA_W/8-1:0] byte_enable,
    input  logic                rw,
    input  logic [DATA_W-1:0]   write_data,
    output logic                acknowledge,
    output logic [DATA_W-1:0]   read_data,
    inout  wire  [DATA_W-1:0]   SRAM_DQ,
    output logic [ADDR_W-2:0]   SRAM_ADDR,
    output logic                SRAM_CE_N,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N,
    output logic [DATA_W/8-1:0] SRAM_BE_N
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] LP_WAIT = wait_load(WAIT_STATES);

    state_t              r_state;
    logic                r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-2:0]   r_addr;
    logic [BE_W-1:0]     r_be;
    logic                r_rw;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_ce_n;
    logic                r_we_n;
    logic                r_oe_n;
    logic [BE_W-1:0]     r_be_n;
    logic                r_dq_oe;

    logic                w_start;
    logic                w_start_rw;
    logic [BE_W-1:0]     w_start_be;
    logic                w_cnt_dec;
    logic                w_cnt_zero;
    logic                w_unused;

    assign w_unused = address[0];

`ifdef SRAM_TURNAROUND_EN
    logic r_last_rd;
    logic w_need_turn;

    // A write right after a read waits one cycle so the SRAM releases DQ
    assign w_need_turn = r_last_rd && (rw == RW_WRITE);
    assign w_start = ((r_state == ST_IDLE) && bus_enable && !w_need_turn)
                   || (r_state == ST_TURN);
`else
    assign w_start = (r_state == ST_IDLE) && bus_enable;
`endif

    assign w_start_rw = (r_state == ST_IDLE) ? rw : r_rw;
    assign w_start_be = (r_state == ST_IDLE) ? byte_enable : r_be;
    assign w_cnt_dec  = (r_state == ST_ACCESS);

    sram_wait_counter u_wait_cnt (
        .i_clk      (clk_clk),
        .i_rst_n    (reset_reset_n),
        .i_load     (w_start),
        .i_load_val (LP_WAIT),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state   <= ST_IDLE;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_be      <= '0;
            r_rw      <= RW_READ;
            r_wdata   <= '0;
            r_ce_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_be_n    <= '1;
            r_dq_oe   <= 1'b0;
`ifdef SRAM_TURNAROUND_EN
            r_last_rd <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus_enable) begin
                        r_addr  <= address[ADDR_W-1:1];
                        r_be    <= byte_enable;
                        r_rw    <= rw;
                        r_wdata <= write_data;
`ifdef SRAM_TURNAROUND_EN
                        if (w_need_turn) begin
                            r_state <= ST_TURN;
                        end
`endif
                    end
                end
                ST_ACCESS: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                        r_ce_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_be_n  <= '1;
                        if (r_rw == RW_READ) begin
                            r_rdata <= SRAM_DQ;
                        end
`ifdef SRAM_TURNAROUND_EN
                        r_last_rd <= (r_rw == RW_READ);
`endif
                    end
                end
                ST_ACK: begin
                    // Write data is held for exactly one cycle past WE_N rising
                    r_dq_oe <= 1'b0;
                    if (!bus_enable) begin
                        r_state <= ST_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
`ifdef SRAM_TURNAROUND_EN
                ST_TURN: begin
                    r_last_rd <= 1'b0;
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_start) begin
                r_state <= ST_ACCESS;
                r_ce_n  <= 1'b0;
                r_we_n  <= (w_start_rw == RW_READ);
                r_oe_n  <= (w_start_rw == RW_WRITE);
                r_be_n  <= ~w_start_be;
                r_dq_oe <= (w_start_rw == RW_WRITE);
            end
        end
    end

    assign SRAM_DQ     = r_dq_oe ? r_wdata : {DATA_W{1'bz}};
    assign acknowledge = r_ack;
    assign read_data   = r_rdata;
    assign SRAM_ADDR   = r_addr;
    assign SRAM_CE_N   = r_ce_n;
    assign SRAM_WE_N   = r_we_n;
    assign SRAM_OE_N   = r_oe_n;
    assign SRAM_BE_N   = r_be_n;

endmodule

// File: tb/tb_sram_wait_ctrl.sv
// tb_sram_wait_ctrl: directed transfers against a small SRAM model.
// Expected responses are queued by the driver and checked by a monitor on acknowledge.
module tb_sram_wait_ctrl;

    localparam int AW = 19;
    localparam int DW = 16;
    localparam int WS = 1;
`ifdef SRAM_TURNAROUND_EN
    localparam int TURN = 1;
`else
    localparam int TURN = 0;
`endif

    logic          clk_clk = 1'b0;
    logic          reset_reset_n = 1'b0;
    logic [AW-1:0] address = '0;
    logic          bus_enable = 1'b0;
    logic [1:0]    byte_enable = '0;
    logic          rw = 1'b1;
    logic [DW-1:0] write_data = '0;
    logic          acknowledge;
    logic [DW-1:0] read_data;
    wire  [DW-1:0] SRAM_DQ;
    logic [AW-2:0] SRAM_ADDR;
    logic          SRAM_CE_N;
    logic          SRAM_WE_N;
    logic          SRAM_OE_N;
    logic [1:0]    SRAM_BE_N;

    sram_wait_ctrl #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WAIT_STATES (WS)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .address       (address),
        .bus_enable    (bus_enable),
        .byte_enable   (byte_enable),
        .rw            (rw),
        .write_data    (write_data),
        .acknowledge   (acknowledge),
        .read_data     (read_data),
        .SRAM_DQ       (SRAM_DQ),
        .SRAM_ADDR     (SRAM_ADDR),
        .SRAM_CE_N     (SRAM_CE_N),
        .SRAM_WE_N     (SRAM_WE_N),
        .SRAM_OE_N     (SRAM_OE_N),
        .SRAM_BE_N     (SRAM_BE_N)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc++;

    // SRAM model; an undriven bus floats high
    logic [DW-1:0] mem [256];
    pullup pu_dq (SRAM_DQ);
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;

    always @(posedge clk_clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            if (!SRAM_BE_N[0]) mem[SRAM_ADDR[7:0]][7:0]  <= SRAM_DQ[7:0];
            if (!SRAM_BE_N[1]) mem[SRAM_ADDR[7:0]][15:8] <= SRAM_DQ[15:8];
        end
    end

    typedef struct {
        logic        rd;
        logic [17:0] addr;
        logic [1:0]  ben;
        logic [15:0] wd;
        logic [15:0] rdat;
        int          lat;
        int          req;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_rd = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic xfer(input logic rd, input logic [AW-1:0] a, input logic [1:0] be,
                        input logic [15:0] wd, input logic [17:0] ea,
                        input logic [1:0] eben, input logic [15:0] erd);
        exp_t e;
        int   n;
        @(negedge clk_clk);
        address     = a;
        byte_enable = be;
        rw          = rd;
        write_data  = wd;
        bus_enable  = 1'b1;
        e.rd   = rd;
        e.addr = ea;
        e.ben  = eben;
        e.wd   = wd;
        e.rdat = erd;
        e.lat  = WS + 2 + ((TURN != 0 && !rd && prev_rd) ? 1 : 0);
        e.req  = cyc;
        q.push_back(e);
        n = 0;
        do begin
            @(negedge clk_clk);
            n++;
        end while (!acknowledge && n < 40);
        if (!acknowledge) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout: got no acknowledge, want one within 40 cycles");
        end
        bus_enable = 1'b0;
        // Stimulus is changed after ack to show the latch is not re-read
        address    = '1;
        write_data = 16'h0BAD;
        prev_rd    = rd;
    endtask

    logic        prev_ack = 1'b0;
    logic        chk_z = 1'b0;
    int          n_acc = 0;
    int          n_we = 0;
    int          n_oe = 0;
    logic        dq_bad = 1'b0;
    logic        lane_bad = 1'b0;
    logic [1:0]  be_seen = '0;
    logic [17:0] addr_seen = '0;

    always @(negedge clk_clk) begin
        exp_t e;
        if (!reset_reset_n) begin
            prev_ack = 1'b0;
            chk_z    = 1'b0;
            n_acc    = 0;
            n_we     = 0;
            n_oe     = 0;
            dq_bad   = 1'b0;
            lane_bad = 1'b0;
        end else begin
            if (chk_z) begin
                chk("dq_release", SRAM_DQ, 16'hffff);
                chk_z = 1'b0;
            end
            if (!SRAM_CE_N) begin
                if (n_acc == 0) begin
                    be_seen   = SRAM_BE_N;
                    addr_seen = SRAM_ADDR;
                end else if (SRAM_BE_N !== be_seen || SRAM_ADDR !== addr_seen) begin
                    lane_bad = 1'b1;
                end
                n_acc++;
                if (!SRAM_WE_N) begin
                    n_we++;
                    if (q.size() > 0 && SRAM_DQ !== q[0].wd) dq_bad = 1'b1;
                end
                if (!SRAM_OE_N) n_oe++;
            end
            if (acknowledge && !prev_ack) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: got acknowledge, want none (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("latency", 32'(cyc - e.req), 32'(e.lat));
                    chk("sram_addr", 32'(addr_seen), 32'(e.addr));
                    chk("be_n", 32'(be_seen), 32'(e.ben));
                    chk("access_cycles", 32'(n_acc), 32'(WS + 1));
                    chk("we_cycles", 32'(n_we), e.rd ? 32'd0 : 32'(WS + 1));
                    chk("oe_cycles", 32'(n_oe), e.rd ? 32'(WS + 1) : 32'd0);
                    chk("lanes_stable", 32'(lane_bad), 32'd0);
                    chk("read_data", 32'(read_data), 32'(e.rdat));
                    chk("ack_strobes", {SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_BE_N}, 32'h1f);
                    if (e.rd) begin
                        chk("dq_ack_read", SRAM_DQ, 16'hffff);
                    end else begin
                        chk("dq_write_data", 32'(dq_bad), 32'd0);
                        chk("dq_hold", SRAM_DQ, e.wd);
                    end
                end
                n_acc    = 0;
                n_we     = 0;
                n_oe     = 0;
                dq_bad   = 1'b0;
                lane_bad = 1'b0;
                chk_z    = 1'b1;
            end
            prev_ack = acknowledge;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA500 + 16'(i);
        repeat (3) @(negedge clk_clk);
        chk("rst_ack", 32'(acknowledge), 32'd0);
        chk("rst_read_data", 32'(read_data), 32'd0);
        chk("rst_strobes", {SRAM_CE_N, SRAM_WE_N, SRAM_OE_N}, 32'h7);
        chk("rst_be_n", 32'(SRAM_BE_N), 32'h3);
        chk("rst_sram_addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst_dq", SRAM_DQ, 16'hffff);
        reset_reset_n = 1'b1;
        repeat (2) @(negedge clk_clk);
        chk("idle_strobes", {SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_BE_N}, 32'h1f);
        chk("idle_dq", SRAM_DQ, 16'hffff);

        //   rd    address      be     wdata     sram_addr   be_n   read_data
        xfer(1'b0, 19'h00010, 2'b11, 16'hBEEF, 18'h00008, 2'b00, 16'h0000);
        xfer(1'b1, 19'h00010, 2'b11, 16'h0000, 18'h00008, 2'b00, 16'hBEEF);
        xfer(1'b0, 19'h00011, 2'b01, 16'h1234, 18'h00008, 2'b10, 16'hBEEF);
        xfer(1'b1, 19'h00010, 2'b11, 16'h0000, 18'h00008, 2'b00, 16'hBE34);
        xfer(1'b0, 19'h00020, 2'b00, 16'h9999, 18'h00010, 2'b11, 16'hBE34);
        xfer(1'b1, 19'h00020, 2'b11, 16'h0000, 18'h00010, 2'b00, 16'hA510);
        xfer(1'b0, 19'h00031, 2'b10, 16'h7766, 18'h00018, 2'b01, 16'hA510);
        xfer(1'b1, 19'h00030, 2'b11, 16'h0000, 18'h00018, 2'b00, 16'h7718);
        xfer(1'b0, 19'h7FFFE, 2'b11, 16'hCAFE, 18'h3FFFF, 2'b00, 16'h7718);
        xfer(1'b1, 19'h7FFFE, 2'b11, 16'h0000, 18'h3FFFF, 2'b00, 16'hCAFE);
        xfer(1'b0, 19'h00040, 2'b11, 16'h5555, 18'h00020, 2'b00, 16'hCAFE);
        xfer(1'b1, 19'h00040, 2'b11, 16'h0000, 18'h00020, 2'b00, 16'h5555);

        // Abort a read with reset during its second access cycle
        @(negedge clk_clk);
        address     = 19'h00010;
        byte_enable = 2'b11;
        rw          = 1'b1;
        bus_enable  = 1'b1;
        @(negedge clk_clk);
        @(negedge clk_clk);
        chk("abort_in_access", {SRAM_CE_N, SRAM_OE_N}, 32'h0);
        reset_reset_n = 1'b0;
        bus_enable    = 1'b0;
        @(negedge clk_clk);
        chk("abort_strobes", {SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_BE_N}, 32'h1f);
        chk("abort_ack", 32'(acknowledge), 32'd0);
        chk("abort_read_data", 32'(read_data), 32'd0);
        reset_reset_n = 1'b1;
        prev_rd       = 1'b0;
        repeat (4) @(negedge clk_clk);
        chk("abort_no_ack", 32'(acknowledge), 32'd0);

        xfer(1'b1, 19'h00010, 2'b11, 16'h0000, 18'h00008, 2'b00, 16'hBE34);
        xfer(1'b0, 19'h00010, 2'b11, 16'h0F0F, 18'h00008, 2'b00, 16'hBE34);
        xfer(1'b1, 19'h00010, 2'b11, 16'h0000, 18'h00008, 2'b00, 16'h0F0F);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk_clk);
        repeat (2) @(negedge clk_clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
